sample_debounce: RTL and testbench
==================================

Name: sample_debounce

Overview:
- Conditioning stage directly upstream of the sampling register blocks (the clk/a -> x flop stages).
- Synchronises a raw asynchronous level `a`, then debounces it: the level must be stable for STABLE_CYCLES enabled samples before it is accepted.
- Produces a clean level `x` plus one-cycle rise/fall pulses that downstream register stages consume directly.

Parameters:
- SYNC_STAGES, 2: number of synchroniser flops; legal range 2..4.
- STABLE_CYCLES, 4: consecutive en-qualified differing samples required to accept a new level; legal range 1..(2**CNT_W)-1.
- CNT_W, 8: stability counter width.

Ports:
- clk  input  1  sole clock; all flops rise-edge triggered.
- rst_n  input  1  reset, asynchronous assert, active-low.
- a  input  1  raw asynchronous input level.
- en  input  1  sample-enable tick; tie to 1 for per-cycle sampling.
- x  output  1  debounced level, registered.
- rise  output  1  one-cycle pulse in the cycle x goes 0->1.
- fall  output  1  one-cycle pulse in the cycle x goes 1->0.
- busy  output  1  high while a candidate level change is being qualified.
- (optional) glitch_cnt  output  CNT_W  rejected-change count; see Optional Feature.

Behaviour:
- Reset (rst_n=0, async): all sync flops 0, state S_LO, cnt 0. Outputs: x=0, rise=0, fall=0, busy=0, glitch_cnt=0.
- Synchroniser: a_s is the last stage of the SYNC_STAGES chain. It ignores en and shifts every cycle.
- FSM states: S_LO, S_LO_CHK, S_HI, S_HI_CHK.
  - x=1 in S_HI and S_HI_CHK, otherwise 0.
  - busy=1 in the *_CHK states.
  - All outputs are registered or decoded from registered state only; there is no combinational path from a or en.
- FSM transitions (apply only when en=1; with en=0, state and cnt hold and rise/fall are 0):
  - S_LO and a_s=1:
    - STABLE_CYCLES=1 -> go to S_HI, pulse rise.
    - Otherwise -> go to S_LO_CHK, cnt<=1.
  - S_LO_CHK and a_s=1:
    - cnt==STABLE_CYCLES-1 -> go to S_HI, cnt<=0, pulse rise.
    - Otherwise -> cnt<=cnt+1.
  - S_LO_CHK and a_s=0: go to S_LO, cnt<=0; counts as a glitch.
  - S_HI / S_HI_CHK: mirror of the above with a_s=0, pulsing fall.
- Latency with en tied to 1:
  - a toggles before edge 1 and stays put -> x toggles at edge SYNC_STAGES+STABLE_CYCLES.
  - Defaults: edge 6.
  - rise/fall is high for exactly the cycle following that edge.
- Glitch rejection: any en-qualified sample equal to x during *_CHK aborts qualification. x never changes and no pulse is issued.
- Sparse en: only en=1 samples count toward STABLE_CYCLES; en=0 cycles neither advance nor abort qualification.
- Reset mid-qualification: returns to S_LO immediately, and no pulse is issued on reset or on deassertion. If a is high at release, x rises after the normal latency, with a rise pulse.
- rise and fall are never high in the same cycle. Consecutive pulses are at least STABLE_CYCLES en-cycles apart.

Optional Feature:
- Macro: SAMPLE_DEBOUNCE_GLITCH_CNT_EN.
- Defined:
  - glitch_cnt port exists.
  - Increments by 1 on every aborted qualification.
  - Saturates at all-ones.
  - Cleared only by reset.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package sample_pkg:
  - typedef enum for the four FSM states.
  - Default constants SAMPLE_SYNC_STAGES=2, SAMPLE_STABLE_CYCLES=4, SAMPLE_CNT_W=8.
- Sub-module sample_sync: parameterised SYNC_STAGES flop chain with async active-low reset to 0, ports clk, rst_n, d, q. Instantiated once.
- FSM, counter and optional glitch counter live in sample_debounce.

Test Plan:
- Reset then a=1 held, en=1, defaults -> x=0 through edge 5; x=1 at edge 6; rise=1 for one cycle; busy=1 on edges 3..5.
- a=1 for 2 cycles then back to 0, en=1 -> x stays 0; rise never asserts; glitch_cnt=1 with the macro defined.
- en pulsed every 3rd cycle, a=1 held -> x rises only after 4 en-qualified differing samples; no abort during en=0 gaps.
- x=1 steady, a drops to 0, rst_n asserted at edge 4 of qualification -> x=0, fall=0, busy=0 immediately. After release with a=0, x stays 0 with no pulse.
- STABLE_CYCLES=1, a toggled every 4 cycles -> x follows a delayed by SYNC_STAGES+1 edges; alternating single-cycle rise/fall pulses; busy never asserts.
- Macro defined, 300 injected glitches with CNT_W=8 -> glitch_cnt saturates at 255; x unchanged throughout.

Source files
------------

// File: rtl/sample_debounce_pkg.sv
// sample_debounce shared types and defaults.
// FSM state encoding and default parameter values.
package sample_pkg;

    typedef enum logic [1:0] {
        S_LO     = 2'd0,
        S_LO_CHK = 2'd1,
        S_HI     = 2'd2,
        S_HI_CHK = 2'd3
    } sample_state_e;

    localparam int SAMPLE_SYNC_STAGES   = 2;
    localparam int SAMPLE_STABLE_CYCLES = 4;
    localparam int SAMPLE_CNT_W         = 8;

endpackage

// File: rtl/sample_debounce_if.sv
// sample_debounce level/pulse bundle.
// Optional glitch_cnt present with SAMPLE_DEBOUNCE_GLITCH_CNT_EN.
interface sample_debounce_if;
    import sample_pkg::*;

    logic a;
    logic en;
    logic x;
    logic rise;
    logic fall;
    logic busy;
`ifdef SAMPLE_DEBOUNCE_GLITCH_CNT_EN
    // Width tracks the package default counter width.
    logic [SAMPLE_CNT_W-1:0] glitch_cnt;
`endif

    modport master (
        output a, en,
        input  x, rise, fall, busy
`ifdef SAMPLE_DEBOUNCE_GLITCH_CNT_EN
        , input glitch_cnt
`endif
    );

    modport slave (
        input  a, en,
        output x, rise, fall, busy
`ifdef SAMPLE_DEBOUNCE_GLITCH_CNT_EN
        , output glitch_cnt
`endif
    );

endinterface

// File: rtl/sample_debounce_sync.sv
// sample_sync: SYNC_STAGES flop chain for an async level.
// Shifts every cycle; resets to 0.
module sample_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;

    // Shift the raw level through the synchroniser chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/sample_debounce.sv
// sample_debounce: sync + debounce with rise/fall pulses.
// Optional glitch counter: SAMPLE_DEBOUNCE_GLITCH_CNT_EN.
module sample_debounce
    import sample_pkg::*;
#(
    parameter int SYNC_STAGES   = SAMPLE_SYNC_STAGES,
    parameter int STABLE_CYCLES = SAMPLE_STABLE_CYCLES,
    parameter int CNT_W         = SAMPLE_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    sample_debounce_if.slave bus
);

    logic             a_s;
    sample_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             x_w;
    logic             busy_w;

    sample_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (bus.a),
        .q    (a_s)
    );

    // State, stability counter and registered pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_LO;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Qualify a candidate level over en-qualified samples.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (bus.en) begin
            unique case (state_q)
                S_LO: begin
                    if (a_s) begin
                        if (STABLE_CYCLES == 1) begin
                            state_d = S_HI;
                            rise_d  = 1'b1;
                        end else begin
                            state_d = S_LO_CHK;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                S_LO_CHK: begin
                    if (!a_s) begin
                        state_d = S_LO;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
                        state_d = S_HI;
                        cnt_d   = '0;
                        rise_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_HI: begin
                    if (!a_s) begin
                        if (STABLE_CYCLES == 1) begin
                            state_d = S_LO;
                            fall_d  = 1'b1;
                        end else begin
                            state_d = S_HI_CHK;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                S_HI_CHK: begin
                    if (a_s) begin
                        state_d = S_HI;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
                        state_d = S_LO;
                        cnt_d   = '0;
                        fall_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign x_w    = (state_q == S_HI) || (state_q == S_HI_CHK);
    assign busy_w = (state_q == S_LO_CHK) || (state_q == S_HI_CHK);

    assign bus.x    = x_w;
    assign bus.busy = busy_w;
    assign bus.rise = rise_q;
    assign bus.fall = fall_q;

`ifdef SAMPLE_DEBOUNCE_GLITCH_CNT_EN
    logic             abort;
    logic [CNT_W-1:0] gcnt_q;

    // A sample matching x while checking abandons the candidate.
    assign abort = bus.en && busy_w && (a_s == x_w);

    // Saturating count of abandoned candidates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gcnt_q <= '0;
        end else if (abort && (gcnt_q != '1)) begin
            gcnt_q <= gcnt_q + CNT_W'(1);
        end
    end

    assign bus.glitch_cnt = SAMPLE_CNT_W'(gcnt_q);
`endif

endmodule

// File: tb/tb_sample_debounce.sv
// Directed bench for sample_debounce.
// Second instance runs with STABLE_CYCLES=1.
module tb_sample_debounce;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    sample_debounce_if bus0();
    sample_debounce_if bus1();

    sample_debounce u_dut0 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus0)
    );

    sample_debounce #(
        .STABLE_CYCLES(1)
    ) u_dut1 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        logic ah [0:31];
        logic ex, px;
        n_chk = 0;
        n_err = 0;
        bus0.a  = 1'b0;
        bus0.en = 1'b1;
        bus1.a  = 1'b0;
        bus1.en = 1'b1;
        rst_n   = 1'b0;
        tick();
        tick();
        chk("rst_x", bus0.x, 0);
        chk("rst_rise", bus0.rise, 0);
        chk("rst_fall", bus0.fall, 0);
        chk("rst_busy", bus0.busy, 0);
`ifdef SAMPLE_DEBOUNCE_GLITCH_CNT_EN
        chk("rst_gcnt", bus0.glitch_cnt, 0);
`endif
        rst_n = 1'b1;

        // Held high: x at edge 6, busy on edges 3..5.
        bus0.a = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            chk("t1_x", bus0.x, 32'(e >= 6));
            chk("t1_busy", bus0.busy, 32'(e >= 3 && e <= 5));
            chk("t1_rise", bus0.rise, 32'(e == 6));
            chk("t1_fall", bus0.fall, 0);
        end

        // Two-cycle glitch is rejected.
        bus0.a = 1'b0;
        do_reset();
        bus0.a = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (e == 2) bus0.a = 1'b0;
            chk("t2_x", bus0.x, 0);
            chk("t2_rise", bus0.rise, 0);
            chk("t2_busy", bus0.busy, 32'(e == 3 || e == 4));
        end
`ifdef SAMPLE_DEBOUNCE_GLITCH_CNT_EN
        chk("t2_gcnt", bus0.glitch_cnt, 1);
`endif

        // Sparse en every 3rd cycle.
        do_reset();
        bus0.a = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            bus0.en = (e % 3 == 0);
            tick();
            chk("t3_x", bus0.x, 32'(e >= 12));
            chk("t3_busy", bus0.busy, 32'(e >= 3 && e < 12));
            chk("t3_rise", bus0.rise, 32'(e == 12));
        end
        bus0.en = 1'b1;

        // Reset mid fall-qualification.
        bus0.a = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            tick();
            chk("t4_x", bus0.x, 1);
            chk("t4_busy", bus0.busy, 32'(e >= 3));
            chk("t4_fall", bus0.fall, 0);
        end
        rst_n = 1'b0;
        #1;
        chk("t4_rx", bus0.x, 0);
        chk("t4_rfall", bus0.fall, 0);
        chk("t4_rbusy", bus0.busy, 0);
        tick();
        rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            chk("t4_px", bus0.x, 0);
            chk("t4_prise", bus0.rise, 0);
            chk("t4_pfall", bus0.fall, 0);
            chk("t4_pbusy", bus0.busy, 0);
        end

`ifdef SAMPLE_DEBOUNCE_GLITCH_CNT_EN
        // 300 single-cycle glitches saturate the counter.
        do_reset();
        chk("t5_gcnt0", bus0.glitch_cnt, 0);
        for (int i = 0; i < 300; i++) begin
            bus0.a = 1'b1;
            tick();
            bus0.a = 1'b0;
            tick();
            chk("t5_x", bus0.x, 0);
        end
        repeat (4) tick();
        chk("t5_gcnt", bus0.glitch_cnt, 255);
        chk("t5_xend", bus0.x, 0);
`endif

        // STABLE_CYCLES=1: x follows a three edges later.
        do_reset();
        px = 1'b0;
        for (int e = 1; e <= 24; e++) begin
            bus1.a = (((e - 1) / 4) % 2 == 0);
            ah[e] = bus1.a;
            tick();
            ex = (e >= 3) ? ah[e-2] : 1'b0;
            chk("t6_x", bus1.x, 32'(ex));
            chk("t6_rise", bus1.rise, 32'(ex && !px));
            chk("t6_fall", bus1.fall, 32'(!ex && px));
            chk("t6_busy", bus1.busy, 0);
            px = ex;
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
